bsram_access_unit: RTL and testbench
====================================

# bsram_access_unit

Request-side initiator for the byte-enabled block RAM (`BSRAM_byte_en`). It accepts byte, halfword and word load/store requests on a byte address through a valid/ready handshake. It drives the RAM's read port and byte-enabled write port, then returns aligned, sign- or zero-extended load data on a response handshake. It sits between a core's memory stage, or a scan/debug master, and one `BSRAM_byte_en` instance.

## Interface
- `DATA_WIDTH`, 32: RAM word width; only 32 is supported.
- `ADDR_WIDTH`, 8: RAM word-address width; the byte address is `ADDR_WIDTH+2` bits.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `req_addr`  in  ADDR_WIDTH+2  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_error`  out  1  misaligned or illegal-size request.
- `mem_readEnable`  out  1  RAM read strobe.
- `mem_readAddress`  out  ADDR_WIDTH  RAM read word address.
- `mem_readData`  in  32  RAM read data; registered in the RAM, valid the cycle after the read strobe.
- `mem_writeEnable`  out  1  RAM write strobe.
- `mem_writeByteEnable`  out  4  RAM byte lanes.
- `mem_writeAddress`  out  ADDR_WIDTH  RAM write word address.
- `mem_writeData`  out  32  lane-replicated store data.

## Operation
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP.
- IDLE: `req_ready`=1. A request is accepted when `req_valid`=1 in IDLE; size, signedness, address and data are registered on that edge.
- Alignment check at accept, with o = `req_addr[1:0]`:
  - half with o[0]=1 is an error;
  - word with o≠0 is an error;
  - size 3 is an error.
  - An error goes to RESP with `rsp_error`=1 and `rsp_rdata`=0. No RAM access is made.
- Word address is `req_addr[ADDR_WIDTH+1:2]`.
- Accepted store goes to WRITE. Accepted load goes to RD_ISSUE.
- WRITE, one cycle: `mem_writeEnable`=1, then go to RESP.
  - byte: `mem_writeByteEnable` = 4'b0001<<o; `mem_writeData` = {4{wdata[7:0]}}.
  - half: `mem_writeByteEnable` = 4'b0011<<o; `mem_writeData` = {2{wdata[15:0]}}.
  - word: `mem_writeByteEnable` = 4'b1111; `mem_writeData` = wdata.
- RD_ISSUE, one cycle: `mem_readEnable`=1 with the word address, then go to RD_WAIT.
- RD_WAIT, one cycle: sample `mem_readData`, extract and extend, register into `rsp_rdata`, then go to RESP.
  - byte result: bits [8o+7:8o].
  - half result: bits [8o+15:8o].
  - word result: the whole word.
  - Extension sets bits above the field to 0 (unsigned) or to the field MSB (signed).
- RESP: `rsp_valid`=1 with `rsp_rdata`/`rsp_error` held stable. Return to IDLE on the edge where `rsp_ready`=1.
  - A new request is not accepted in the same cycle; `req_ready`=0 in RESP.
- Outside their states: `mem_readEnable`, `mem_writeEnable` and `mem_writeByteEnable` are 0. Addresses and `mem_writeData` hold their last value.
- At most one RAM access is outstanding; a write and a read are never issued in the same cycle.

## Timing
- Reset values: state IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_rdata`=0; `rsp_error`=0; all `mem_*` outputs 0.
- Accept on edge k puts the unit in the next state for cycle k+1.
- Store: WRITE in cycle k+1, `rsp_valid` from cycle k+2.
- Load: RD_ISSUE k+1, RD_WAIT k+2, `rsp_valid` from k+3.
- Error: `rsp_valid` from cycle k+1.
- With `rsp_ready` held 1, throughput is one store per 3 cycles and one load per 4 cycles.
- Responses are returned strictly in acceptance order.
- Reset asserted mid-operation aborts the access: outputs go to reset values immediately and no response is produced. A write whose strobe was already sampled by the RAM is not rolled back.
- `rsp_ready` already 1 when `rsp_valid` rises: the unit spends exactly one cycle in RESP.

## Test plan
- Word store 0xAAAA8888 to byte address 0x08, then word load 0x08: one write with BE=1111 at word 2; `rsp_rdata`=0xAAAA8888 three cycles after the load accept; `rsp_error`=0.
- Half store 0x0064 to 0x08: BE=0011, writeData=0x00640064; a following word load returns 0xAAAA0064.
- Byte loads from word 0xAAAA0064:
  - address 0x0A signed returns 0xFFFFFFAA;
  - address 0x0A unsigned returns 0x000000AA;
  - address 0x08 signed returns 0x00000064.
- Half loads: 0x0A signed returns 0xFFFFAAAA; a byte store 0x11 to 0x0B gives BE=1000 and a later word load returns 0x11AA0064.
- Errors: half at 0x09, word at 0x0E, and size 3 each give `rsp_error`=1 and `rsp_rdata`=0 one cycle after accept, with `mem_writeEnable` and `mem_readEnable` never asserted.
- Backpressure and reset:
  - `rsp_ready`=0 for 5 cycles: `rsp_valid`/`rsp_rdata` stay stable and `req_ready`=0.
  - `reset` pulled low during RD_WAIT: all outputs read 0 and `req_ready`=1 immediately; after release the next load completes normally.

Source files
------------

// File: rtl/bsram_access_unit.sv
// bsram_access_unit: byte/half/word load-store initiator for BSRAM_byte_en.
// Registered RAM strobes, aligned + extended load data, response handshake.
module bsram_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  mem_readEnable,
  output logic [ADDR_WIDTH-1:0] mem_readAddress,
  input  logic [DATA_WIDTH-1:0] mem_readData,
  output logic                  mem_writeEnable,
  output logic [3:0]            mem_writeByteEnable,
  output logic [ADDR_WIDTH-1:0] mem_writeAddress,
  output logic [DATA_WIDTH-1:0] mem_writeData
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WRITE    = 3'd1;
  localparam logic [2:0] RD_ISSUE = 3'd2;
  localparam logic [2:0] RD_WAIT  = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [2:0]            state;
  logic [1:0]            sizeQ;
  logic                  unsQ;
  logic [1:0]            offQ;
  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic                  reqError;
  logic [3:0]            reqBe;
  logic [DATA_WIDTH-1:0] reqWdata;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] loadData;

  assign off       = req_addr[1:0];
  assign wordAddr  = req_addr[ADDR_WIDTH+1:2];
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Request decode: alignment check, lane enables and lane replication
  always_comb begin
    reqError = 1'b0;
    reqBe    = 4'b0000;
    reqWdata = req_wdata;
    unique case (req_size)
      2'd0: begin
        reqBe    = 4'b0001 << off;
        reqWdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        reqError = off[0];
        reqBe    = 4'b0011 << off;
        reqWdata = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        reqError = (off != 2'd0);
        reqBe    = 4'b1111;
      end
      default: reqError = 1'b1;
    endcase
  end

  // Load extraction: shift the addressed field down, then extend
  always_comb begin
    shifted  = mem_readData >> {offQ, 3'b000};
    loadData = shifted;
    unique case (sizeQ)
      2'd0:    loadData = {{24{~unsQ & shifted[7]}}, shifted[7:0]};
      2'd1:    loadData = {{16{~unsQ & shifted[15]}}, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  // Control FSM; RAM strobes are launched on the accept edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      sizeQ               <= 2'd0;
      unsQ                <= 1'b0;
      offQ                <= 2'd0;
      rsp_rdata           <= '0;
      rsp_error           <= 1'b0;
      mem_readEnable      <= 1'b0;
      mem_readAddress     <= '0;
      mem_writeEnable     <= 1'b0;
      mem_writeByteEnable <= 4'b0000;
      mem_writeAddress    <= '0;
      mem_writeData       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            sizeQ     <= req_size;
            unsQ      <= req_unsigned;
            offQ      <= off;
            rsp_rdata <= '0;
            rsp_error <= reqError;
            if (reqError) begin
              state <= RESP;
            end else if (req_write) begin
              state               <= WRITE;
              mem_writeEnable     <= 1'b1;
              mem_writeByteEnable <= reqBe;
              mem_writeAddress    <= wordAddr;
              mem_writeData       <= reqWdata;
            end else begin
              state           <= RD_ISSUE;
              mem_readEnable  <= 1'b1;
              mem_readAddress <= wordAddr;
            end
          end
        end
        WRITE: begin
          mem_writeEnable     <= 1'b0;
          mem_writeByteEnable <= 4'b0000;
          state               <= RESP;
        end
        RD_ISSUE: begin
          mem_readEnable <= 1'b0;
          state          <= RD_WAIT;
        end
        RD_WAIT: begin
          rsp_rdata <= loadData;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsram_access_unit.sv
// tb_bsram_access_unit: directed + random load/store traffic against
// a byte-array reference model, with a behavioural registered-read RAM.
module tb_bsram_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_readEnable;
  logic [7:0]  mem_readAddress;
  logic [31:0] mem_readData;
  logic        mem_writeEnable;
  logic [3:0]  mem_writeByteEnable;
  logic [7:0]  mem_writeAddress;
  logic [31:0] mem_writeData;

  int nChk = 0;
  int nErr = 0;
  int wrCount = 0;
  int rdCount = 0;
  int bothCount = 0;

  logic [31:0] ram [256];
  logic [7:0]  model [1024];
  logic [3:0]  lastBe;
  logic [31:0] lastWdata;
  logic [7:0]  lastWaddr;

  always #5 clock = ~clock;

  bsram_access_unit dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .mem_readEnable(mem_readEnable),
    .mem_readAddress(mem_readAddress),
    .mem_readData(mem_readData),
    .mem_writeEnable(mem_writeEnable),
    .mem_writeByteEnable(mem_writeByteEnable),
    .mem_writeAddress(mem_writeAddress),
    .mem_writeData(mem_writeData)
  );

  // Byte-enabled RAM with registered read, plus strobe bookkeeping
  always @(posedge clock) begin
    if (mem_writeEnable) begin
      for (int i = 0; i < 4; i++)
        if (mem_writeByteEnable[i])
          ram[mem_writeAddress][8*i +: 8] <= mem_writeData[8*i +: 8];
      lastBe    <= mem_writeByteEnable;
      lastWdata <= mem_writeData;
      lastWaddr <= mem_writeAddress;
      wrCount   <= wrCount + 1;
    end
    if (mem_readEnable) begin
      mem_readData <= ram[mem_readAddress];
      rdCount      <= rdCount + 1;
    end
    if (mem_readEnable && mem_writeEnable)
      bothCount <= bothCount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nChk++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic doTx(input logic w, input logic [1:0] sz,
                      input logic uns, input logic [9:0] a,
                      input logic [31:0] wd, input int hold);
    logic        err;
    logic [1:0]  o;
    logic [31:0] exp, mask, be, wdx, held;
    int nb, lat, cyc, w0, r0;
    o   = a[1:0];
    err = (sz == 2'd3) || (sz == 2'd1 && o[0]) ||
          (sz == 2'd2 && o != 2'd0);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lat = err ? 1 : (w ? 2 : 3);
    exp = 32'd0;
    if (!err && !w) begin
      for (int i = 0; i < nb; i++)
        exp = exp | (32'(model[int'(a) + i]) << (8 * i));
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      if (!uns && exp[8*nb-1]) exp = exp | ~mask;
    end
    cyc = 0;
    @(negedge clock);
    while (!req_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("idle before request", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    rsp_ready    = (hold == 0);
    w0 = wrCount;
    r0 = rdCount;
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == 1) req_valid = 1'b0;
    end while (!rsp_valid && cyc < 10);
    chk("latency", cyc, lat);
    chk("rsp_rdata", rsp_rdata, exp);
    chk("rsp_error", {31'd0, rsp_error}, {31'd0, err});
    chk("write strobes", wrCount - w0, (!err && w) ? 1 : 0);
    chk("read strobes", rdCount - r0, (!err && !w) ? 1 : 0);
    if (!err && w) begin
      be  = (sz == 2'd0) ? (32'd1 << o) :
            (sz == 2'd1) ? (32'd3 << o) : 32'hF;
      wdx = (sz == 2'd0) ? {4{wd[7:0]}} :
            (sz == 2'd1) ? {2{wd[15:0]}} : wd;
      chk("write byte enable", {28'd0, lastBe}, be);
      chk("write data", lastWdata, wdx);
      chk("write address", {24'd0, lastWaddr}, {24'd0, a[9:2]});
      for (int i = 0; i < nb; i++)
        model[int'(a) + i] = wd[8*i +: 8];
    end
    if (hold > 0) begin
      held = rsp_rdata;
      repeat (hold) begin
        @(posedge clock);
        #1;
        chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp rsp_rdata", rsp_rdata, held);
        chk("bp req_ready", {31'd0, req_ready}, 32'd0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("single resp cycle", {31'd0, rsp_valid}, 32'd0);
    chk("ready after resp", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, " rsp_error"}, {31'd0, rsp_error}, 32'd0);
    chk({tag, " mem strobes"},
        {26'd0, mem_readEnable, mem_writeEnable, mem_writeByteEnable},
        32'd0);
    chk({tag, " mem addresses"},
        {16'd0, mem_readAddress, mem_writeAddress}, 32'd0);
    chk({tag, " mem_writeData"}, mem_writeData, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    for (int i = 0; i < 1024; i++) model[i] = 8'd0;
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 10'd0;
    req_wdata    = 32'd0;
    rsp_ready    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chkResetOutputs("reset");
    @(negedge clock);
    reset = 1'b1;

    doTx(1'b1, 2'd2, 1'b0, 10'h08, 32'hAAAA8888, 0);
    doTx(1'b0, 2'd2, 1'b0, 10'h08, 32'd0, 0);
    chk("word load value", rsp_rdata, 32'hAAAA8888);
    doTx(1'b1, 2'd1, 1'b0, 10'h08, 32'h00000064, 0);
    doTx(1'b0, 2'd2, 1'b0, 10'h08, 32'd0, 0);
    doTx(1'b0, 2'd0, 1'b0, 10'h0A, 32'd0, 0);
    doTx(1'b0, 2'd0, 1'b1, 10'h0A, 32'd0, 0);
    doTx(1'b0, 2'd0, 1'b0, 10'h08, 32'd0, 0);
    doTx(1'b0, 2'd1, 1'b0, 10'h0A, 32'd0, 0);
    doTx(1'b1, 2'd0, 1'b0, 10'h0B, 32'h00000011, 0);
    doTx(1'b0, 2'd2, 1'b0, 10'h08, 32'd0, 0);
    chk("byte merge value", rsp_rdata, 32'h11AA0064);
    doTx(1'b0, 2'd1, 1'b0, 10'h09, 32'd0, 0);
    doTx(1'b1, 2'd2, 1'b0, 10'h0E, 32'h12345678, 0);
    doTx(1'b0, 2'd3, 1'b0, 10'h08, 32'd0, 0);
    doTx(1'b0, 2'd2, 1'b0, 10'h08, 32'd0, 5);

    // Reset pulled during RD_WAIT
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 10'h08;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chkResetOutputs("mid reset");
    @(negedge clock);
    reset = 1'b1;
    doTx(1'b0, 2'd2, 1'b0, 10'h08, 32'd0, 0);

    for (int n = 0; n < 80; n++) begin
      doTx(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)),
           $urandom, (n % 16 == 7) ? 3 : 0);
    end
    chk("read/write overlap", bothCount, 0);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
